// File: rtl/sphere_pkg.sv
// rtl/sphere_pkg.sv - shared types, colour table and fixed-point helper for the sphere register file
package sphere_pkg;
  localparam int FIX_W = 64;

  typedef logic signed [FIX_W-1:0] fixed_real;
  typedef logic [2:0][FIX_W-1:0]   vector;
  typedef logic [23:0]             color;

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_UPDATE = 1'b1
  } state_t;

  // Entry k is the colour of every ball whose index is k mod 4.
  localparam logic [3:0][23:0] COLOR_TABLE = {24'hffff00, 24'hff0000, 24'h00ff00, 24'h0000ff};

  function automatic fixed_real to_fix(input int whole, input int frac);
    fixed_real v;
    v = {{(FIX_W-32){whole[31]}}, whole};
    return v <<< frac;
  endfunction
endpackage

// File: rtl/lfsr64.sv
// rtl/lfsr64.sv - free-running 64-bit Galois LFSR supplying respawn randomness
module lfsr64 #(
  parameter logic [63:0] SEED = 64'h9E37_79B9_7F4A_7C15
) (
  input  logic        Clk,
  input  logic        Reset,
  output logic [63:0] rnd
);
  // Taps for x^64 + x^63 + x^61 + x^60 + 1 (maximal length).
  localparam logic [63:0] TAPS = 64'hD800_0000_0000_0000;

  logic [63:0] r_state;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= SEED;
    end else begin
      r_state <= {1'b0, r_state[63:1]} ^ (r_state[0] ? TAPS : 64'd0);
    end
  end

  assign rnd = r_state;
endmodule

// File: rtl/sphere_reg_n.sv
// rtl/sphere_reg_n.sv - sphere state register file with a one-ball-per-cycle frame physics pass and read port
module sphere_reg_n
  import sphere_pkg::*;
#(
  parameter int NUM_SPHERES = 4,
  parameter int IDX_W       = $clog2(NUM_SPHERES),
  parameter int W           = 64,
  parameter int FRAC        = 32,
  parameter int GRAVITY     = 4,
  parameter int FLOOR_Y     = 2880,
  parameter int SPAWN_Y     = 2400,
  parameter int SPAWN_X     = 2400,
  parameter int SPAWN_Z     = 4800,
  parameter int LAUNCH_VY   = 200
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Frame_Clk,
  input  logic             Hit,
  input  logic [IDX_W-1:0] Hit_index,
  input  logic [IDX_W-1:0] Read_index,
  output logic [3*W-1:0]   Sphere_pos,
  output logic [23:0]      Sphere_col,
  output logic [IDX_W-1:0] curr_index,
  output logic             Busy,
  output logic             Frame_Done,
  output logic             Overrun
);
  typedef logic [2:0][W-1:0] vec_t;

  localparam logic [W-1:0] C_GRAV   = W'(to_fix(GRAVITY, FRAC));
  localparam logic [W-1:0] C_FLOOR  = W'(to_fix(-FLOOR_Y, FRAC));
  localparam logic [W-1:0] C_LAUNCH = W'(to_fix(LAUNCH_VY, FRAC));

  function automatic vec_t spawn_pos(input int i);
    vec_t p;
    p[0] = W'(to_fix((i % 2 == 0) ? -SPAWN_X : SPAWN_X, FRAC));
    p[1] = W'(to_fix(SPAWN_Z + (i >> 1) * SPAWN_Z, FRAC));
    p[2] = W'(to_fix(-SPAWN_Y, FRAC));
    return p;
  endfunction

  function automatic logic [W-1:0] sx_rnd(input logic [15:0] r);
    return {{(W-16){r[15]}}, r} << 20;
  endfunction

  vec_t                   r_pos [NUM_SPHERES];
  vec_t                   r_vel [NUM_SPHERES];
  color                   r_col [NUM_SPHERES];
  logic [NUM_SPHERES-1:0] r_pend;

  state_t           r_state, w_state_nxt;
  logic [IDX_W-1:0] r_idx, w_idx_nxt;
  logic             r_frame_old;
  logic             r_busy, r_done, r_overrun;
  logic             w_edge, w_last, w_done_nxt;

  vec_t             r_rd_pos;
  color             r_rd_col;
  logic [IDX_W-1:0] r_rd_idx;

  logic [63:0] w_rnd;
  logic        w_unused_rnd;

  vec_t w_pos_cur, w_vel_cur, w_va, w_pn, w_vel_resp;
  logic w_hit_ok, w_hit_now, w_respawn;

  lfsr64 u_lfsr (
    .Clk  (Clk),
    .Reset(Reset),
    .rnd  (w_rnd)
  );

  assign w_unused_rnd = ^w_rnd[63:32];

  assign w_edge = Frame_Clk & ~r_frame_old;
  assign w_last = (r_idx == IDX_W'(NUM_SPHERES - 1));

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_edge) begin
          w_state_nxt = S_UPDATE;
          w_idx_nxt   = '0;
        end
      end
      S_UPDATE: begin
        if (w_last) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end else begin
          w_idx_nxt = r_idx + 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Semi-implicit step: velocity updated first, position integrates the new velocity.
  always_comb begin
    w_pos_cur = r_pos[r_idx];
    w_vel_cur = r_vel[r_idx];
    w_va      = w_vel_cur;
    w_va[2]   = w_vel_cur[2] - C_GRAV;
    for (int k = 0; k < 3; k++) begin
      w_pn[k] = w_pos_cur[k] + w_va[k];
    end
    w_vel_resp = {C_LAUNCH, sx_rnd(w_rnd[15:0]), sx_rnd(w_rnd[31:16])};
  end

  assign w_hit_ok  = Hit && (32'(Hit_index) < NUM_SPHERES);
  assign w_hit_now = w_hit_ok && (r_state == S_UPDATE) && (Hit_index == r_idx);
  assign w_respawn = ($signed(w_pos_cur[2]) < $signed(C_FLOOR)) || r_pend[r_idx] || w_hit_now;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_frame_old <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_overrun   <= 1'b0;
      r_pend      <= '0;
      for (int i = 0; i < NUM_SPHERES; i++) begin
        r_pos[i] <= spawn_pos(i);
        r_vel[i] <= '0;
        r_col[i] <= COLOR_TABLE[2'(i)];
      end
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_frame_old <= Frame_Clk;
      r_busy      <= (w_state_nxt == S_UPDATE);
      r_done      <= w_done_nxt;
      r_overrun   <= w_edge && (r_state == S_UPDATE);
      if (r_state == S_UPDATE) begin
        if (w_respawn) begin
          r_pos[r_idx]  <= spawn_pos(32'(r_idx));
          r_vel[r_idx]  <= w_vel_resp;
          r_col[r_idx]  <= COLOR_TABLE[2'(r_idx)];
          r_pend[r_idx] <= 1'b0;
        end else begin
          r_pos[r_idx] <= w_pn;
          r_vel[r_idx] <= w_va;
        end
      end
      // A hit on the ball being written right now is consumed immediately instead of queued.
      if (w_hit_ok && !w_hit_now) begin
        r_pend[Hit_index] <= 1'b1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_rd_pos <= '0;
      r_rd_col <= '0;
      r_rd_idx <= '0;
    end else begin
      r_rd_idx <= Read_index;
      if (32'(Read_index) < NUM_SPHERES) begin
        r_rd_pos <= r_pos[Read_index];
        r_rd_col <= r_col[Read_index];
      end else begin
        r_rd_pos <= '0;
        r_rd_col <= '0;
      end
    end
  end

  assign Sphere_pos = r_rd_pos;
  assign Sphere_col = r_rd_col;
  assign curr_index = r_rd_idx;
  assign Busy       = r_busy;
  assign Frame_Done = r_done;
  assign Overrun    = r_overrun;
endmodule

// File: tb/tb_sphere_reg_n.sv
// tb/tb_sphere_reg_n.sv - directed scoreboard bench for sphere_reg_n
module tb_sphere_reg_n;
  localparam int N  = 4;
  localparam int IW = 2;
  localparam int W  = 64;

  logic            Clk = 1'b0;
  logic            Reset, Frame_Clk, Hit;
  logic [IW-1:0]   Hit_index, Read_index;
  logic [3*W-1:0]  Sphere_pos;
  logic [23:0]     Sphere_col;
  logic [IW-1:0]   curr_index;
  logic            Busy, Frame_Done, Overrun;

  always #5 Clk = ~Clk;

  sphere_reg_n #(.NUM_SPHERES(N)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Frame_Clk (Frame_Clk),
    .Hit       (Hit),
    .Hit_index (Hit_index),
    .Read_index(Read_index),
    .Sphere_pos(Sphere_pos),
    .Sphere_col(Sphere_col),
    .curr_index(curr_index),
    .Busy      (Busy),
    .Frame_Done(Frame_Done),
    .Overrun   (Overrun)
  );

  int n_tests = 0;
  int n_fail  = 0;

  longint m_pos [N][3];
  longint m_vel2 [N];
  bit     m_xz_ok [N];
  bit     m_xzv_unk [N];
  bit     m_pend [N];

  typedef struct {
    int          idx;
    bit          xz;
    logic [63:0] p0, p1, p2;
    logic [23:0] col;
  } exp_t;
  exp_t sb[$];

  localparam logic [23:0] COLS [4] = '{24'h0000ff, 24'h00ff00, 24'hff0000, 24'hffff00};

  function automatic longint fix(input longint w);
    return w <<< 32;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_spawn(input int i);
    m_pos[i][0] = (i % 2 == 0) ? fix(-2400) : fix(2400);
    m_pos[i][1] = fix(4800 + (i / 2) * 4800);
    m_pos[i][2] = fix(-2400);
    m_xz_ok[i]  = 1'b1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      model_spawn(i);
      m_vel2[i]    = 0;
      m_xzv_unk[i] = 1'b0;
      m_pend[i]    = 1'b0;
    end
  endtask

  task automatic model_step(input int hit_now);
    for (int i = 0; i < N; i++) begin
      if (m_pos[i][2] < fix(-2880) || m_pend[i] || i == hit_now) begin
        model_spawn(i);
        m_vel2[i]    = fix(200);
        m_xzv_unk[i] = 1'b1;
        m_pend[i]    = 1'b0;
      end else begin
        m_vel2[i]   = m_vel2[i] - fix(4);
        m_pos[i][2] = m_pos[i][2] + m_vel2[i];
        if (m_xzv_unk[i]) m_xz_ok[i] = 1'b0;
      end
    end
  endtask

  task automatic read_ball(input int i);
    exp_t e;
    @(negedge Clk);
    Read_index = IW'(i);
    e.idx = i;
    e.xz  = m_xz_ok[i];
    e.p0  = m_pos[i][0];
    e.p1  = m_pos[i][1];
    e.p2  = m_pos[i][2];
    e.col = COLS[i % 4];
    sb.push_back(e);
    @(negedge Clk);
    e = sb.pop_front();
    chk($sformatf("rd%0d_idx", i), 64'(curr_index), 64'(e.idx));
    chk($sformatf("rd%0d_col", i), 64'(Sphere_col), 64'(e.col));
    chk($sformatf("rd%0d_pos2", i), Sphere_pos[191:128], e.p2);
    if (e.xz) begin
      chk($sformatf("rd%0d_pos0", i), Sphere_pos[63:0], e.p0);
      chk($sformatf("rd%0d_pos1", i), Sphere_pos[127:64], e.p1);
    end
  endtask

  task automatic read_all();
    for (int i = 0; i < N; i++) read_ball(i);
  endtask

  task automatic run_frame(input int ovr_at, input int hit_idx,
                           output int nb, output int nd, output int no, output int dk);
    nb = 0; nd = 0; no = 0; dk = -1;
    @(negedge Clk);
    Frame_Clk = 1'b1;
    @(negedge Clk);
    Frame_Clk = 1'b0;
    if (hit_idx >= 0) begin
      Hit       = 1'b1;
      Hit_index = IW'(hit_idx);
    end
    for (int k = 0; k < 8; k++) begin
      if (Busy) nb++;
      if (Frame_Done) begin nd++; dk = k; end
      if (Overrun) no++;
      if (k == 1) Hit = 1'b0;
      if (k == ovr_at) Frame_Clk = 1'b1;
      if (k == ovr_at + 1) Frame_Clk = 1'b0;
      @(negedge Clk);
    end
  endtask

  task automatic frame_check(input string tag, input int ovr_at, input int hit_idx, input int exp_ovr);
    int nb, nd, no, dk;
    run_frame(ovr_at, hit_idx, nb, nd, no, dk);
    chk({tag, "_busy_cycles"}, 64'(nb), 64'd4);
    chk({tag, "_done_pulses"}, 64'(nd), 64'd1);
    chk({tag, "_done_cycle"}, 64'(dk), 64'd4);
    chk({tag, "_overrun"}, 64'(no), 64'(exp_ovr));
    model_step(hit_idx);
  endtask

  initial begin
    Reset      = 1'b1;
    Frame_Clk  = 1'b0;
    Hit        = 1'b0;
    Hit_index  = '0;
    Read_index = '0;
    repeat (3) @(negedge Clk);
    chk("rst_busy", 64'(Busy), 64'd0);
    chk("rst_done", 64'(Frame_Done), 64'd0);
    chk("rst_overrun", 64'(Overrun), 64'd0);
    chk("rst_pos_hi", Sphere_pos[191:128], 64'd0);
    chk("rst_pos_lo", Sphere_pos[63:0], 64'd0);
    chk("rst_col", 64'(Sphere_col), 64'd0);
    chk("rst_idx", 64'(curr_index), 64'd0);
    Reset = 1'b0;
    model_reset();

    read_ball(1);
    read_all();

    frame_check("f1", -1, -1, 0);
    chk("f1_ball0_model", 64'(m_pos[0][2]), 64'(fix(-2404)));
    read_all();

    for (int f = 2; f <= 16; f++) frame_check($sformatf("f%0d", f), -1, -1, 0);
    read_all();

    frame_check("f17", -1, -1, 0);
    read_all();
    frame_check("f18", -1, -1, 0);
    read_all();

    @(negedge Clk);
    Hit       = 1'b1;
    Hit_index = 2'd2;
    @(negedge Clk);
    Hit = 1'b0;
    m_pend[2] = 1'b1;
    frame_check("f19", -1, -1, 0);
    read_all();
    frame_check("f20", -1, -1, 0);
    read_all();

    frame_check("f21_hit0", -1, 0, 0);
    read_all();

    frame_check("f22_ovr", 1, -1, 1);
    read_all();

    @(negedge Clk);
    Frame_Clk = 1'b1;
    @(negedge Clk);
    Frame_Clk = 1'b0;
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    chk("midrst_busy", 64'(Busy), 64'd0);
    chk("midrst_pos", Sphere_pos[191:128], 64'd0);
    Reset = 1'b0;
    model_reset();
    read_all();
    frame_check("f_after_rst", -1, -1, 0);
    read_all();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
